cla_acc_sat: RTL and testbench

CLA_ACC_SAT -- requirements
Module: cla_acc_sat

---
 rtl/cla_acc_sat.sv | 251 +++++++++++++++++++++++++
 tb/tb_cla_acc_sat.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cla_acc_sat.sv
// -----------------------------------------------------------------------------
// cla_acc_sat -- signed carry-lookahead adder/accumulator with overflow flags
//
// Adds two signed WIDTH-bit operands (mode=0: a+b) or accumulates
// (mode=1: acc+a, with the result written back to acc). The adder is built
// from WIDTH/GRP lookahead groups. The result is held in a one-deep output
// register with a valid/ready handshake and full throughput.
//
// Build option: define CLA_ACC_SAT_EN to clamp sum (and the acc write-back)
// to the signed range on overflow/underflow. Without it the result wraps.
//
// Parameters
//   WIDTH      signed operand/result width (4..64)
//   GRP        lookahead group size, must divide WIDTH
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat present
//   in_ready   block can accept a beat (low while in reset)
//   a, b       signed operands (b ignored when mode=1)
//   mode       0: a+b, 1: acc+a with write-back to acc
//   acc_clr    synchronous accumulator clear
//   out_valid  result register holds an unconsumed result
//   out_ready  consumer accepts the result
//   sum        signed result
//   ovf, uvf   per-result overflow / underflow flags aligned with sum
//   ovf_sticky, uvf_sticky  latched flags
//   sticky_clr clears both sticky flags (a coincident set wins)
// -----------------------------------------------------------------------------
module cla_acc_sat #(
    parameter int WIDTH = 8,
    parameter int GRP   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             ovf,
    output logic             uvf,
    output logic             ovf_sticky,
    output logic             uvf_sticky,
    input  logic             sticky_clr
);

    localparam int NG = WIDTH / GRP;

    generate
        if ((WIDTH < 4) || (WIDTH > 64) || ((WIDTH % GRP) != 0)) begin : g_param_check
            $error("cla_acc_sat: WIDTH must be 4..64 and divisible by GRP");
        end
    endgenerate

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] sum_r;
    logic             out_valid_r;
    logic             ovf_r;
    logic             uvf_r;
    logic             ovf_sticky_r;
    logic             uvf_sticky_r;

    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic [WIDTH-1:0] raw_s;
    logic [WIDTH-1:0] res_s;
    logic             ovf_s;
    logic             uvf_s;
    logic             accept_s;

    // Handshake: the output register can take a new result when empty or draining.
    always_comb begin
        in_ready = rst_n & (~out_valid_r | out_ready);
        accept_s = in_valid & in_ready;
    end

    // Operand selection; a clear coinciding with an accumulate beat adds to zero.
    always_comb begin
        op_a_s = a;
        op_b_s = b;
        if (mode) begin
            if (acc_clr) begin
                op_a_s = {WIDTH{1'b0}};
            end else begin
                op_a_s = acc_r;
            end
            op_b_s = a;
        end else begin
            op_a_s = a;
            op_b_s = b;
        end
    end

    // Carry-lookahead adder: group G/P terms, lookahead across groups, then
    // lookahead inside each group from that group's carry-in.
    always_comb begin : cla_add
        logic [WIDTH-1:0] g_v;
        logic [WIDTH-1:0] p_v;
        logic [WIDTH-1:0] c_v;
        logic [NG-1:0]    gg_v;
        logic [NG-1:0]    gp_v;
        logic [NG-1:0]    gc_v;
        logic             t_v;
        logic             cy_v;

        g_v  = op_a_s & op_b_s;
        p_v  = op_a_s ^ op_b_s;
        c_v  = {WIDTH{1'b0}};
        gg_v = {NG{1'b0}};
        gp_v = {NG{1'b1}};
        gc_v = {NG{1'b0}};
        t_v  = 1'b0;
        cy_v = 1'b0;

        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GRP; j++) begin
                gg_v[k] = g_v[k*GRP+j] | (p_v[k*GRP+j] & gg_v[k]);
                gp_v[k] = gp_v[k] & p_v[k*GRP+j];
            end
        end

        // Carry into group k: OR over earlier groups m of G[m] & P[m+1..k-1].
        for (int k = 1; k < NG; k++) begin
            cy_v = 1'b0;
            for (int m = 0; m < k; m++) begin
                t_v = gg_v[m];
                for (int n = m + 1; n < k; n++) begin
                    t_v = t_v & gp_v[n];
                end
                cy_v = cy_v | t_v;
            end
            gc_v[k] = cy_v;
        end

        // Carry into bit j of group k, expanded from the group carry-in.
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GRP; j++) begin
                cy_v = gc_v[k];
                for (int n = 0; n < j; n++) begin
                    cy_v = cy_v & p_v[k*GRP+n];
                end
                for (int m = 0; m < j; m++) begin
                    t_v = g_v[k*GRP+m];
                    for (int n = m + 1; n < j; n++) begin
                        t_v = t_v & p_v[k*GRP+n];
                    end
                    cy_v = cy_v | t_v;
                end
                c_v[k*GRP+j] = cy_v;
            end
        end

        raw_s = p_v ^ c_v;
    end

    // Signed overflow detection from operand and raw-result sign bits.
    always_comb begin
        ovf_s = ~op_a_s[WIDTH-1] & ~op_b_s[WIDTH-1] &  raw_s[WIDTH-1];
        uvf_s =  op_a_s[WIDTH-1] &  op_b_s[WIDTH-1] & ~raw_s[WIDTH-1];
    end

`ifdef CLA_ACC_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp the result to the signed range on overflow/underflow.
    always_comb begin
        res_s = raw_s;
        if (ovf_s) begin
            res_s = SAT_MAX;
        end else if (uvf_s) begin
            res_s = SAT_MIN;
        end else begin
            res_s = raw_s;
        end
    end
`else
    // Two's-complement wrapped result.
    always_comb begin
        res_s = raw_s;
    end
`endif

    // Output register: load on accept, drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            ovf_r       <= 1'b0;
            uvf_r       <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            sum_r       <= res_s;
            ovf_r       <= ovf_s;
            uvf_r       <= uvf_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Accumulator: accumulate beats write back; otherwise a clear zeroes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {WIDTH{1'b0}};
        end else if (accept_s && mode) begin
            acc_r <= res_s;
        end else if (acc_clr) begin
            acc_r <= {WIDTH{1'b0}};
        end else begin
            acc_r <= acc_r;
        end
    end

    // Sticky flags: a set on an accepted beat beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_r <= 1'b0;
            uvf_sticky_r <= 1'b0;
        end else begin
            if (accept_s && ovf_s) begin
                ovf_sticky_r <= 1'b1;
            end else if (sticky_clr) begin
                ovf_sticky_r <= 1'b0;
            end else begin
                ovf_sticky_r <= ovf_sticky_r;
            end
            if (accept_s && uvf_s) begin
                uvf_sticky_r <= 1'b1;
            end else if (sticky_clr) begin
                uvf_sticky_r <= 1'b0;
            end else begin
                uvf_sticky_r <= uvf_sticky_r;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign sum        = sum_r;
    assign ovf        = ovf_r;
    assign uvf        = uvf_r;
    assign ovf_sticky = ovf_sticky_r;
    assign uvf_sticky = uvf_sticky_r;

endmodule

// File: tb/tb_cla_acc_sat.sv
// -----------------------------------------------------------------------------
// tb_cla_acc_sat -- self-checking bench for cla_acc_sat (WIDTH=8, GRP=4)
//
// Directed scenarios for wrap/saturation, accumulation, back-pressure, reset
// and sticky flags, then randomized traffic. Expected values come from an
// integer-arithmetic model of the handshake, accumulator and flags.
// -----------------------------------------------------------------------------
module tb_cla_acc_sat;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       ovf;
    logic       uvf;
    logic       ovf_sticky;
    logic       uvf_sticky;
    logic       sticky_clr;

    int checks_n;
    int fail_n;

    // reference model state (signed values held as plain ints)
    int m_acc;
    int m_sum;
    bit m_valid;
    bit m_ovf;
    bit m_uvf;
    bit m_ovf_st;
    bit m_uvf_st;

    cla_acc_sat #(.WIDTH(8), .GRP(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .mode       (mode),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .ovf        (ovf),
        .uvf        (uvf),
        .ovf_sticky (ovf_sticky),
        .uvf_sticky (uvf_sticky),
        .sticky_clr (sticky_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks_n++;
        if (obs != exp) begin
            fail_n++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".out_valid"}, longint'(out_valid), longint'(m_valid));
        check_val({tag, ".sum"}, longint'($signed(sum)), longint'(m_sum));
        check_val({tag, ".ovf"}, longint'(ovf), longint'(m_ovf));
        check_val({tag, ".uvf"}, longint'(uvf), longint'(m_uvf));
        check_val({tag, ".ovf_sticky"}, longint'(ovf_sticky), longint'(m_ovf_st));
        check_val({tag, ".uvf_sticky"}, longint'(uvf_sticky), longint'(m_uvf_st));
    endtask

    task automatic model_reset();
        m_acc = 0; m_sum = 0; m_valid = 0; m_ovf = 0; m_uvf = 0;
        m_ovf_st = 0; m_uvf_st = 0;
    endtask

    // One clock cycle: drive at the falling edge, check in_ready, advance the
    // model, then check registered outputs at the next falling edge.
    task automatic step(input string tag, input bit iv, input int av, input int bv,
                        input bit md, input bit clr, input bit ordy, input bit sclr);
        logic [7:0] a8;
        logic [7:0] b8;
        int  opa, opb, s, res;
        bit  rdy, acc_ok, o, u;
        a8 = 8'(av);
        b8 = 8'(bv);
        in_valid = iv; a = a8; b = b8; mode = md; acc_clr = clr;
        out_ready = ordy; sticky_clr = sclr;
        #1;
        rdy = !m_valid || ordy;
        check_val({tag, ".in_ready"}, longint'(in_ready), longint'(rdy));
        acc_ok = iv && rdy;
        opa = md ? (clr ? 0 : m_acc) : int'($signed(a8));
        opb = md ? int'($signed(a8)) : int'($signed(b8));
        s   = opa + opb;
        o   = (s > 127);
        u   = (s < -128);
`ifdef CLA_ACC_SAT_EN
        res = o ? 127 : (u ? -128 : s);
`else
        res = o ? s - 256 : (u ? s + 256 : s);
`endif
        if (acc_ok) begin
            m_valid = 1; m_sum = res; m_ovf = o; m_uvf = u;
        end else if (ordy) begin
            m_valid = 0;
        end
        if (acc_ok && md) m_acc = res;
        else if (clr) m_acc = 0;
        if (acc_ok && o) m_ovf_st = 1;
        else if (sclr) m_ovf_st = 0;
        if (acc_ok && u) m_uvf_st = 1;
        else if (sclr) m_uvf_st = 0;
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        checks_n = 0;
        fail_n   = 0;
        model_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; a = 8'd0; b = 8'd0; mode = 1'b0; acc_clr = 1'b0;
        out_ready = 1'b0; sticky_clr = 1'b0;
        @(negedge clk);
        check_outputs("reset");
        check_val("reset.in_ready", longint'(in_ready), 64'sd0);
        @(negedge clk);
        rst_n = 1'b1;

        // wrap / saturate on overflow and underflow
        step("ovf", 1'b1, 127, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("uvf", 1'b1, -128, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("clr_st", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);

        // accumulate 50 three times, then clear coinciding with a beat
        step("accclr", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("acc1", 1'b1, 50, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("acc2", 1'b1, 50, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("acc3", 1'b1, 50, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("acc_clr5", 1'b1, 5, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        step("acc_after", 1'b1, 7, 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // back-pressure: 20 pending, new beat offered while stalled
        step("bp_load", 1'b1, 12, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        step("bp_stall", 1'b1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("bp_stall2", 1'b1, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("bp_go", 1'b1, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle("bp_drain");

        // asynchronous reset mid-accumulation with a pending result
        step("rst_pre1", 1'b1, 30, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("rst_pre2", 1'b1, 100, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b1; mode = 1'b1; a = 8'd9;
        #1;
        model_reset();
        check_outputs("rst_async");
        check_val("rst_async.in_ready", longint'(in_ready), 64'sd0);
        @(posedge clk);
        @(negedge clk);
        check_outputs("rst_hold");
        rst_n = 1'b1;
        step("rst_post", 1'b1, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // sticky clear coincident with an overflow beat, then alone
        step("st_set", 1'b1, 100, 100, 1'b0, 1'b0, 1'b1, 1'b1);
        step("st_uvf", 1'b1, -100, -100, 1'b0, 1'b0, 1'b1, 1'b0);
        step("st_clr", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
        $finish;
    end

endmodule
